// File: rtl/msd_to_bin_pkg.sv
// Shared definitions for the MSD-to-binary converter: digit codes,
// converter FSM states and the chunk-count helper.
package msd_pkg;

    // Two-bit signed-digit encodings carried on the MSD bus
    localparam logic [1:0] MSD_ZERO = 2'b00;
    localparam logic [1:0] MSD_POS  = 2'b01;
    localparam logic [1:0] MSD_NEG  = 2'b11;
    localparam logic [1:0] MSD_ILL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } msd_state_e;

    // Number of CHUNK-wide slices needed to cover a width-bit value
    function automatic int msd_nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/msd_to_bin_chunk_sub.sv
// Combinational CHUNK-bit subtractor with borrow chain: diff = a - b - borrow_in.
module msd_chunk_sub #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] diff,
    output logic             borrow_out
);

    logic [CHUNK:0] full;

    // One extra bit catches the borrow: it is set whenever the difference goes negative
    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
    end

    assign diff       = full[CHUNK-1:0];
    assign borrow_out = full[CHUNK];

endmodule

// File: rtl/msd_to_bin.sv
// MSD-to-binary converter. Captures one (P+2)-digit signed-digit word, forms
// POS - NEG chunk-serially (CHUNK bits per cycle) and holds the two's-complement
// result until the consumer takes it.
// Optional build macro: MSD2BIN_ERR_CHK_EN enables latching of illegal digit
// codes into out_err; without it out_err is tied low.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. in_valid/in_msd may change freely while not accepted; out_valid,
// out_bin and out_err hold steady until out_ready is seen high on an edge.
module msd_to_bin
    import msd_pkg::*;
#(
    parameter int P     = 33,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*P+3:0]   in_msd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P+2:0]     out_bin,
    output logic             out_err
);

    localparam int D  = P + 2;                      // digits per word
    localparam int W  = D + 1;                      // result width
    localparam int NC = msd_nchunk(W, CHUNK);       // conversion cycles
    localparam int WP = NC * CHUNK;                 // padded working width
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    msd_state_e    state;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [WP-1:0] pos_q;
    logic [WP-1:0] neg_q;
    logic [WP-1:0] res_q;
    logic [WP-1:0] res_next;
    logic [WP-1:0] pos_in;
    logic [WP-1:0] neg_in;
    logic          borrow_q;
    logic [CW-1:0] cnt_q;
    logic [CHUNK-1:0] diff;
    logic          borrow_out;
    logic          accept;

    assign accept = (state == IDLE) && in_valid && in_ready_q;

    // Split the digit word into positive and negative bit vectors; illegal codes count as zero
    always_comb begin
        pos_in = '0;
        neg_in = '0;
        for (int i = 0; i < D; i++) begin
            pos_in[i] = (in_msd[2*i +: 2] == MSD_POS);
            neg_in[i] = (in_msd[2*i +: 2] == MSD_NEG);
        end
    end

    // The low CHUNK bits of the shifting POS/NEG registers are always the current chunk
    msd_chunk_sub #(.CHUNK(CHUNK)) u_sub (
        .a          (pos_q[CHUNK-1:0]),
        .b          (neg_q[CHUNK-1:0]),
        .borrow_in  (borrow_q),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // Each new chunk enters at the top and slides down, so chunk 0 lands at bit 0 after NC steps
    generate
        if (NC == 1) begin : g_single
            assign res_next = diff;
        end else begin : g_multi
            assign res_next = {diff, res_q[WP-1:CHUNK]};
        end
    endgenerate

    // Converter FSM: capture in IDLE, one chunk per cycle in CONV, hold result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pos_q       <= '0;
            neg_q       <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        pos_q      <= pos_in;
                        neg_q      <= neg_in;
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    res_q    <= res_next;
                    borrow_q <= borrow_out;
                    pos_q    <= pos_q >> CHUNK;
                    neg_q    <= neg_q >> CHUNK;
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = res_q[W-1:0];

`ifdef MSD2BIN_ERR_CHK_EN
    logic err_in;
    logic err_q;

    // Flag any illegal digit code in the incoming word
    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < D; i++) begin
            err_in = err_in | (in_msd[2*i +: 2] == MSD_ILL);
        end
    end

    // Error flag follows the word: set at capture, dropped when the result is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= err_in;
        end else if (state == DONE && out_ready) begin
            err_q <= 1'b0;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_msd_to_bin.sv
// Testbench for msd_to_bin at default parameters (P=33, CHUNK=8, 36-bit result).
module tb_msd_to_bin;

    localparam int P  = 33;
    localparam int D  = P + 2;
    localparam int W  = D + 1;
    localparam int MW = 2 * P + 4;
    localparam int NC = 5;

`ifdef MSD2BIN_ERR_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_msd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_bin;
    logic          out_err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];

    msd_to_bin #(.P(P), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msd    (in_msd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- model: value = sum of d_i * 2^i ----------------
    function automatic logic [W:0] model(input logic [MW-1:0] w);
        longint     v;
        logic       e;
        logic [1:0] dg;
        v = 0;
        e = 1'b0;
        for (int i = 0; i < D; i++) begin
            dg = w[2*i +: 2];
            if (dg == 2'b01)      v = v + (longint'(1) << i);
            else if (dg == 2'b11) v = v - (longint'(1) << i);
            else if (dg == 2'b10) e = 1'b1;
        end
        return {e & ERR_EN, v[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Accepted words are pushed with their model result; taken results are popped.
    always @(posedge clk or posedge rst) begin
        logic [W:0] m;
        if (rst) begin
            exp_q.delete();
            exp_err_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                m = model(in_msd);
                exp_q.push_back(m[W-1:0]);
                exp_err_q.push_back(m[W]);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(exp_err_q.pop_front());
            end
        end
    end

    // Every cycle a result is presented it must match the oldest accepted word
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: out_valid=1 with out_bin %h but no word expected", out_bin);
            end else begin
                check("sb_bin", out_bin, exp_q[0]);
                check("sb_err", W'(out_err), W'(exp_err_q[0]));
            end
        end
    end

    // ---------------- drivers ----------------
    // Present a word at a falling edge, hold it through the accepting edge, then scramble it.
    task automatic send_word(input logic [MW-1:0] w);
        int g;
        g = 0;
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        in_valid = 1'b1;
        in_msd   = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_msd   = {$urandom, $urandom, $urandom};
    endtask

    // Send a word, check latency and literal result, stall for hold cycles, then take it.
    task automatic run_word(input string name, input logic [MW-1:0] w,
                            input logic [W-1:0] exp_bin, input logic exp_err, input int hold);
        int lat;
        send_word(w);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, W'(lat), W'(NC + 1));
        check({name, "_bin"}, out_bin, exp_bin);
        check({name, "_err"}, W'(out_err), W'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, W'(out_valid), W'(1));
            check({name, "_hold_bin"}, out_bin, exp_bin);
            check({name, "_hold_ready"}, W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_post_valid"}, W'(out_valid), W'(0));
        check({name, "_post_ready"}, W'(in_ready), W'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_msd    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_bin", out_bin, W'(0));
        check("rst_out_err", W'(out_err), W'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", W'(in_ready), W'(1));

        // Hand-computed literals
        run_word("zero",    '0,                              36'h0_0000_0000, 1'b0, 0);
        run_word("d0_pos",  70'h1,                           36'h0_0000_0001, 1'b0, 0);
        run_word("d0_neg",  70'h3,                           36'hF_FFFF_FFFF, 1'b0, 0);
        run_word("d1p_d0n", 70'h7,                           36'h0_0000_0001, 1'b0, 0);
        run_word("all_pos", {35{2'b01}},                     36'h7_FFFF_FFFF, 1'b0, 0);
        run_word("all_neg", {35{2'b11}},                     36'h8_0000_0001, 1'b0, 0);

        // Backpressure then an immediate second word
        run_word("stall",   {2'b01, 66'b0, 2'b11},           36'h3_FFFF_FFFF, 1'b0, 3);
        run_word("b2b",     {35{2'b11}},                     36'h8_0000_0001, 1'b0, 0);

        // Illegal digit 5
        run_word("ill_d5",  70'h800,                         36'h0_0000_0000, ERR_EN, 0);

        // Peak throughput with out_ready held high: next accept NC+2 cycles later
        out_ready = 1'b1;
        send_word({2'b01, {17{4'b1101}}});
        n = 1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tput_gap", W'(n), W'(NC + 2));
        send_word({35{2'b01}});
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tput_drain", W'(exp_q.size()), W'(0));
        out_ready = 1'b0;
        @(negedge clk);

        // Reset during the third CONV cycle abandons the word
        send_word({35{2'b01}});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", W'(out_valid), W'(0));
        check("mid_rst_bin", out_bin, W'(0));
        check("mid_rst_err", W'(out_err), W'(0));
        check("mid_rst_ready", W'(in_ready), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", W'(in_ready), W'(1));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("mid_rst_no_out", W'(n), W'(0));
        run_word("after_rst", 70'h1, 36'h0_0000_0001, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
